cbfp_factor_accum: RTL

- Successor to the two-input scale-factor adder in the FFT output path.
- Accumulates per-point CBFP block-exponent (scale) factors from NUM_STAGES CBFP stages for every point of an FFT frame, delivering LANES points per beat.
- Stage streams arrive time-staggered and may overlap across two frames, so factors are held in a ping-pong accumulation buffer.
- The final-stage beat releases the registered total factor to the output de-normalisation logic.

---
 rtl/cbfp_factor_pkg.sv | 22 ++
 rtl/cbfp_stage_tracker.sv | 41 ++++
 rtl/cbfp_factor_accum.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cbfp_factor_pkg.sv
// cbfp_factor_pkg
//   Shared types and default sizing for the CBFP scale-factor accumulator.
//   fac_t        : one stage's per-point scale factor
//   sum_t        : accumulated per-point factor across all stages
//   bank_state_e : ping-pong bank occupancy state
package cbfp_factor_pkg;

  localparam int unsigned DEF_FACTOR_WIDTH = 5;
  localparam int unsigned DEF_NUM_STAGES   = 3;
  localparam int unsigned DEF_LANES        = 16;
  localparam int unsigned DEF_FRAME_BEATS  = 32;
  localparam int unsigned DEF_SUM_WIDTH    = DEF_FACTOR_WIDTH + $clog2(DEF_NUM_STAGES);

  typedef logic [DEF_FACTOR_WIDTH-1:0] fac_t;
  typedef logic [DEF_SUM_WIDTH-1:0]    sum_t;

  typedef enum logic {
    BANK_FREE    = 1'b0,
    BANK_FILLING = 1'b1
  } bank_state_e;

endpackage

// File: rtl/cbfp_stage_tracker.sv
// cbfp_stage_tracker
//   Per-stage beat counter and ping-pong bank pointer.
//   clk, rst : clock, asynchronous active-high reset
//   advance  : a beat for this stage is accepted this cycle
//   cnt      : beat index of the next/current beat within the frame
//   bp       : bank the current frame of this stage lives in
//   beat0    : current beat is beat 0 of a frame
//   wrap     : current accepted beat is the last beat of the frame
module cbfp_stage_tracker
  import cbfp_factor_pkg::*;
#(
  parameter  int unsigned FRAME_BEATS = DEF_FRAME_BEATS,
  localparam int unsigned BW          = $clog2(FRAME_BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [BW-1:0] cnt,
  output logic          bp,
  output logic          beat0,
  output logic          wrap
);

  assign beat0 = (cnt == '0);
  assign wrap  = advance && (cnt == BW'(FRAME_BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      bp  <= 1'b0;
    end else if (advance) begin
      if (wrap) begin
        cnt <= '0;
        bp  <= ~bp;
      end else begin
        cnt <= cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/cbfp_factor_accum.sv
// cbfp_factor_accum
//   Accumulates per-point CBFP block-exponent factors from NUM_STAGES stages
//   in a two-bank ping-pong buffer; the last stage's beat releases the total.
//   Optional feature: define CBFP_FACTOR_CLAMP_EN to saturate each output lane
//   at CLAMP_MAX (buffer contents stay unclamped).
//   clk, rst       : clock, asynchronous active-high reset
//   in_valid       : one beat of factors for stage in_stage
//   in_stage       : source stage index, 0 = first CBFP stage
//   in_fac         : LANES x FACTOR_WIDTH unsigned factors, lane 0 in LSBs
//   out_valid      : one-cycle pulse per total-factor beat
//   out_beat       : beat index of out_fac within the frame
//   out_fac        : LANES x SUM_WIDTH summed factors, lane 0 in LSBs
//   out_frame_done : pulses with the last output beat of a frame
//   err_order      : sticky protocol error flag, cleared only by rst
module cbfp_factor_accum
  import cbfp_factor_pkg::*;
#(
  parameter  int unsigned FACTOR_WIDTH = DEF_FACTOR_WIDTH,
  parameter  int unsigned NUM_STAGES   = DEF_NUM_STAGES,
  parameter  int unsigned LANES        = DEF_LANES,
  parameter  int unsigned FRAME_BEATS  = DEF_FRAME_BEATS,
  parameter  int unsigned CLAMP_MAX    = 24,
  localparam int unsigned SUM_WIDTH    = FACTOR_WIDTH + $clog2(NUM_STAGES),
  localparam int unsigned STW          = $clog2(NUM_STAGES),
  localparam int unsigned BW           = $clog2(FRAME_BEATS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [STW-1:0]               in_stage,
  input  logic [LANES*FACTOR_WIDTH-1:0] in_fac,
  output logic                         out_valid,
  output logic [BW-1:0]                out_beat,
  output logic [LANES*SUM_WIDTH-1:0]   out_fac,
  output logic                         out_frame_done,
  output logic                         err_order
);

`ifdef CBFP_FACTOR_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif
  localparam logic [SUM_WIDTH-1:0] CLAMP_V = SUM_WIDTH'(CLAMP_MAX);

  // Per-stage trackers
  logic [BW-1:0] cnt   [NUM_STAGES];
  logic          bp    [NUM_STAGES];
  logic          beat0 [NUM_STAGES];
  logic          wrap  [NUM_STAGES];
  logic          adv   [NUM_STAGES];

  logic stage_ok;
  assign stage_ok = in_valid && (32'(in_stage) < NUM_STAGES);

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    assign adv[s] = stage_ok && (32'(in_stage) == s);

    cbfp_stage_tracker #(
      .FRAME_BEATS(FRAME_BEATS)
    ) u_trk (
      .clk    (clk),
      .rst    (rst),
      .advance(adv[s]),
      .cnt    (cnt[s]),
      .bp     (bp[s]),
      .beat0  (beat0[s]),
      .wrap   (wrap[s])
    );
  end

  // Bank bookkeeping and accumulation buffer
  bank_state_e            bank_st [2];
  logic                   done_q  [2][NUM_STAGES];
  logic [SUM_WIDTH-1:0]   fbuf    [2][FRAME_BEATS][LANES];

  // Current-beat decode
  logic [STW-1:0]             sel;
  logic [STW-1:0]             prev;
  logic [BW-1:0]              cur_cnt;
  logic                       cur_bp;
  logic                       cur_beat0;
  logic                       cur_wrap;
  logic                       is_first;
  logic                       is_last;
  logic                       order_bad;
  logic [SUM_WIDTH-1:0]       sum_lane [LANES];
  logic [LANES*SUM_WIDTH-1:0] fac_next;

  always_comb begin
    sel       = stage_ok ? in_stage : '0;
    prev      = '0;
    cur_cnt   = cnt[sel];
    cur_bp    = bp[sel];
    cur_beat0 = beat0[sel];
    cur_wrap  = wrap[sel];
    is_first  = stage_ok && (sel == '0);
    is_last   = stage_ok && (32'(sel) == NUM_STAGES - 1);
    order_bad = 1'b0;

    if (in_valid && !stage_ok) begin
      order_bad = 1'b1;
    end else if (is_first) begin
      if (cur_beat0 && (bank_st[cur_bp] != BANK_FREE)) order_bad = 1'b1;
    end else if (stage_ok) begin
      prev = sel - STW'(1);
      if (cur_beat0 && !done_q[cur_bp][prev]) order_bad = 1'b1;
      // Previous stage still working in this bank must already be past this beat.
      if ((bp[prev] == cur_bp) && (cnt[prev] <= cur_cnt)) order_bad = 1'b1;
    end

    fac_next = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      sum_lane[l] = fbuf[cur_bp][cur_cnt][l]
                  + SUM_WIDTH'(in_fac[l*FACTOR_WIDTH +: FACTOR_WIDTH]);
      if (CLAMP_EN && (sum_lane[l] > CLAMP_V))
        fac_next[l*SUM_WIDTH +: SUM_WIDTH] = CLAMP_V;
      else
        fac_next[l*SUM_WIDTH +: SUM_WIDTH] = sum_lane[l];
    end
  end

  // Bank state, done bits, sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_order <= 1'b0;
      for (int unsigned k = 0; k < 2; k++) begin
        bank_st[k] <= BANK_FREE;
        for (int unsigned s = 0; s < NUM_STAGES; s++) done_q[k][s] <= 1'b0;
      end
    end else begin
      if (order_bad) err_order <= 1'b1;
      if (is_first && cur_beat0) begin
        bank_st[cur_bp] <= BANK_FILLING;
        for (int unsigned s = 0; s < NUM_STAGES; s++) done_q[cur_bp][s] <= 1'b0;
      end
      // Placed after the clear so a wrap in the same cycle wins.
      if (stage_ok && cur_wrap) done_q[cur_bp][sel] <= 1'b1;
      if (is_last && cur_wrap) bank_st[cur_bp] <= BANK_FREE;
    end
  end

  // Accumulation buffer: contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (is_first) begin
      for (int unsigned l = 0; l < LANES; l++)
        fbuf[cur_bp][cur_cnt][l] <= SUM_WIDTH'(in_fac[l*FACTOR_WIDTH +: FACTOR_WIDTH]);
    end else if (stage_ok && !is_last) begin
      for (int unsigned l = 0; l < LANES; l++)
        fbuf[cur_bp][cur_cnt][l] <= sum_lane[l];
    end
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_beat       <= '0;
      out_fac        <= '0;
      out_frame_done <= 1'b0;
    end else begin
      out_valid      <= is_last;
      out_frame_done <= is_last && (cur_cnt == BW'(FRAME_BEATS - 1));
      if (is_last) begin
        out_beat <= cur_cnt;
        out_fac  <= fac_next;
      end
    end
  end

endmodule
